axi_read_arbiter: RTL and testbench
===================================

// Module: axi_read_arbiter
// PURPOSE
//  Read-path arbiter for the AXI interconnect: picks one of two masters (M0, M1), decodes its ARADDR
//  to a target slave, and drives the select code that steers the AR and R channel muxes.
//  Holds the grant across the AR handshake and the full read burst (through the RLAST beat).
//  Exactly one read transaction is outstanding at any time; masters are served round-robin.
// PARAMETERS
//  SEL_W      4      width of select code {mst[3], slv[2:0]}
//  IDLE_SEL   4'hF   select code driven when no grant is held (routes nothing)
// PORTS
//  ACLK         in   1    clock
//  ARESETn      in   1    reset, synchronous, active-low
//  ARVALID_M0   in   1    M0 read-address request
//  ARADDR_M0    in   32   M0 read address
//  ARVALID_M1   in   1    M1 read-address request
//  ARADDR_M1    in   32   M1 read address
//  ARREADY_M0   in   1    muxed AR ready returned to M0 (AR handshake detect)
//  ARREADY_M1   in   1    muxed AR ready returned to M1
//  RVALID_M0    in   1    muxed R valid to M0
//  RREADY_M0    in   1    M0 R ready
//  RLAST_M0     in   1    muxed R last to M0
//  RVALID_M1    in   1    muxed R valid to M1
//  RREADY_M1    in   1    M1 R ready
//  RLAST_M1     in   1    muxed R last to M1
//  AR_arbiter   out  4    AR-channel select; IDLE_SEL when not in ADDR state
//  R_arbiter    out  4    R-channel select; IDLE_SEL when not in DATA state
//  ar_decerr    out  1    one-cycle pulse: granted address was unmapped
// BEHAVIOUR
//  Reset: ARESETn=0 at a rising edge -> state IDLE, AR_arbiter=R_arbiter=IDLE_SEL, ar_decerr=0,
//   rr_last=M1 (M0 wins first tie). Reset mid-ADDR/DATA aborts the transaction at once.
//  Decode (combinational on candidate ARADDR): 0x0000_0000-0x0000_FFFF slv0; 0x0001_0000-0x0001_FFFF slv1;
//   0x0002_0000-0x0002_FFFF slv2; 0x1000_0000-0x1000_03FF slv3; 0x1001_0000-0x1001_FFFF slv4;
//   0x2000_0000-0x201F_FFFF slv5; anything else slv6 (default slave, DECERR responder).
//  FSM (all outputs registered):
//   IDLE: if any ARVALID_Mx -> pick master (one requester: it; both: the one != rr_last);
//    latch sel={mst,slv}; -> ADDR. ar_decerr=1 in the ADDR entry cycle when slv=6.
//   ADDR: AR_arbiter=sel. Exit on ARVALID_Mg & ARREADY_Mg (g=granted master) -> DATA.
//    The non-granted master's request is ignored and never starves the grant. ARVALID_Mg dropping
//    without handshake (protocol violation) -> stay in ADDR, keep grant.
//   DATA: AR_arbiter=IDLE_SEL, R_arbiter=sel. Exit on RVALID_Mg & RREADY_Mg & RLAST_Mg -> IDLE,
//    rr_last<=g. Non-last beats keep DATA.
//  Latency: ARVALID first seen at edge k -> AR_arbiter valid from cycle k+1; RLAST handshake at edge n
//   -> R_arbiter=IDLE_SEL from cycle n+1, new grant earliest at edge n+1 (visible n+2).
//  Round-robin pointer updates only on burst completion, not on grant.
//  No combinational path from any input to any output.
// TESTING
//  T1 M0 ARADDR=0x0001_0040, ARREADY 1 cycle later, 4 R beats -> AR_arbiter=0x1 for ADDR, R_arbiter=0x1 4 beats, then 0xF.
//  T2 M0 and M1 ARVALID same edge from reset, both to 0x0 -> M0 served first (0x0), then M1 (0x8).
//  T3 M1 ARADDR=0x3000_0000 -> AR_arbiter=0xE, ar_decerr pulses 1 cycle, burst completes via default slave.
//  T4 M0 granted, ARREADY_M0 low 5 cycles while M1 requests -> AR_arbiter stays 0x0, M1 waits.
//  T5 ARESETn=0 during DATA beat 2 of 4 -> next cycle both selects 0xF, rr_last=M1.
//  T6 M0 back-to-back reads with M1 idle -> M0 regranted each time, one-cycle IDLE gap between bursts.

Source files
------------

// File: rtl/axi_read_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_read_arbiter_if
//  Description : Request, handshake and select bundle for the two-master AXI read arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_read_arbiter_if #(
    parameter int unsigned SEL_W = 4
);
    logic             ARVALID_M0;
    logic [31:0]      ARADDR_M0;
    logic             ARVALID_M1;
    logic [31:0]      ARADDR_M1;
    logic             ARREADY_M0;
    logic             ARREADY_M1;
    logic             RVALID_M0;
    logic             RREADY_M0;
    logic             RLAST_M0;
    logic             RVALID_M1;
    logic             RREADY_M1;
    logic             RLAST_M1;
    logic [SEL_W-1:0] AR_arbiter;
    logic [SEL_W-1:0] R_arbiter;
    logic             ar_decerr;

    // master: the interconnect side that raises requests and consumes the selects
    modport master (
        output ARVALID_M0, ARADDR_M0, ARVALID_M1, ARADDR_M1,
        output ARREADY_M0, ARREADY_M1,
        output RVALID_M0, RREADY_M0, RLAST_M0,
        output RVALID_M1, RREADY_M1, RLAST_M1,
        input  AR_arbiter, R_arbiter, ar_decerr
    );

    // slave: the arbiter itself
    modport slave (
        input  ARVALID_M0, ARADDR_M0, ARVALID_M1, ARADDR_M1,
        input  ARREADY_M0, ARREADY_M1,
        input  RVALID_M0, RREADY_M0, RLAST_M0,
        input  RVALID_M1, RREADY_M1, RLAST_M1,
        output AR_arbiter, R_arbiter, ar_decerr
    );
endinterface
`default_nettype wire

// File: rtl/axi_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_read_arbiter
//  Description : Round-robin two-master AXI read arbiter with address decode;
//                one outstanding read, grant held through the RLAST beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_read_arbiter #(
    parameter int unsigned      SEL_W    = 4,
    parameter logic [SEL_W-1:0] IDLE_SEL = {SEL_W{1'b1}}
) (
    input  wire logic         ACLK,
    input  wire logic         ARESETn,
    axi_read_arbiter_if.slave bus
);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADDR = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;
    localparam logic [2:0] c_SLV_DEFAULT = 3'd6;

    logic [1:0]       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             rr_last_q, rr_last_d;
    logic [SEL_W-1:0] ar_sel_q, ar_sel_d;
    logic [SEL_W-1:0] r_sel_q, r_sel_d;
    logic             decerr_q, decerr_d;

    function automatic logic [2:0] decode(input logic [31:0] addr);
        logic [2:0] slv;
        if (addr <= 32'h0000_FFFF)                              slv = 3'd0;
        else if (addr >= 32'h0001_0000 && addr <= 32'h0001_FFFF) slv = 3'd1;
        else if (addr >= 32'h0002_0000 && addr <= 32'h0002_FFFF) slv = 3'd2;
        else if (addr >= 32'h1000_0000 && addr <= 32'h1000_03FF) slv = 3'd3;
        else if (addr >= 32'h1001_0000 && addr <= 32'h1001_FFFF) slv = 3'd4;
        else if (addr >= 32'h2000_0000 && addr <= 32'h201F_FFFF) slv = 3'd5;
        else                                                     slv = c_SLV_DEFAULT;
        return slv;
    endfunction

    // Tie goes to the master that did not finish the previous burst
    logic             w_pick_m1;
    logic [2:0]       w_cand_slv;
    logic [SEL_W-1:0] w_cand_sel;
    assign w_pick_m1  = bus.ARVALID_M1 & (~bus.ARVALID_M0 | ~rr_last_q);
    assign w_cand_slv = decode(w_pick_m1 ? bus.ARADDR_M1 : bus.ARADDR_M0);
    assign w_cand_sel = SEL_W'({w_pick_m1, w_cand_slv});

    logic w_gnt;
    logic w_arvalid_g, w_arready_g, w_rvalid_g, w_rready_g, w_rlast_g;
    assign w_gnt       = sel_q[SEL_W-1];
    assign w_arvalid_g = w_gnt ? bus.ARVALID_M1 : bus.ARVALID_M0;
    assign w_arready_g = w_gnt ? bus.ARREADY_M1 : bus.ARREADY_M0;
    assign w_rvalid_g  = w_gnt ? bus.RVALID_M1  : bus.RVALID_M0;
    assign w_rready_g  = w_gnt ? bus.RREADY_M1  : bus.RREADY_M0;
    assign w_rlast_g   = w_gnt ? bus.RLAST_M1   : bus.RLAST_M0;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q   <= c_IDLE;
            sel_q     <= IDLE_SEL;
            rr_last_q <= 1'b1;
            ar_sel_q  <= IDLE_SEL;
            r_sel_q   <= IDLE_SEL;
            decerr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            rr_last_q <= rr_last_d;
            ar_sel_q  <= ar_sel_d;
            r_sel_q   <= r_sel_d;
            decerr_q  <= decerr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_last_d = rr_last_q;
        case (state_q)
            c_IDLE: begin
                if (bus.ARVALID_M0 || bus.ARVALID_M1) begin
                    sel_d   = w_cand_sel;
                    state_d = c_ADDR;
                end
            end
            c_ADDR: begin
                if (w_arvalid_g && w_arready_g) state_d = c_DATA;
            end
            c_DATA: begin
                if (w_rvalid_g && w_rready_g && w_rlast_g) begin
                    state_d   = c_IDLE;
                    rr_last_d = w_gnt;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // Outputs are computed from next state so they leave the flops aligned with the state
    always_comb begin
        ar_sel_d = (state_d == c_ADDR) ? sel_d : IDLE_SEL;
        r_sel_d  = (state_d == c_DATA) ? sel_d : IDLE_SEL;
        decerr_d = (state_q == c_IDLE) && (state_d == c_ADDR) && (sel_d[2:0] == c_SLV_DEFAULT);
    end

    assign bus.AR_arbiter = ar_sel_q;
    assign bus.R_arbiter  = r_sel_q;
    assign bus.ar_decerr  = decerr_q;
endmodule
`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_read_arbiter
//  Description : Directed and random transaction bench for axi_read_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_read_arbiter;
    logic ACLK    = 1'b0;
    logic ARESETn = 1'b0;

    axi_read_arbiter_if #(.SEL_W(4)) bus ();

    axi_read_arbiter #(.SEL_W(4), .IDLE_SEL(4'hF)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

    always #5 ACLK = ~ACLK;

    localparam logic [3:0] c_IDLE_SEL = 4'hF;

    int n_chk  = 0;
    int n_fail = 0;
    int rr_model;   // master that completed the last burst

    logic [31:0] reg_lo [6] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000,
                                32'h1000_0000, 32'h1001_0000, 32'h2000_0000};
    logic [31:0] reg_hi [6] = '{32'h0000_FFFF, 32'h0001_FFFF, 32'h0002_FFFF,
                                32'h1000_03FF, 32'h1001_FFFF, 32'h201F_FFFF};

    function automatic logic [2:0] ref_slv(input logic [31:0] a);
        for (int i = 0; i < 6; i++)
            if (a >= reg_lo[i] && a <= reg_hi[i]) return i[2:0];
        return 3'd6;
    endfunction

    function automatic logic [31:0] rand_addr();
        int r = $urandom_range(0, 7);
        if (r < 6) return reg_lo[r] + ($urandom % (reg_hi[r] - reg_lo[r] + 1));
        if (r == 6) return 32'h4000_0000 + ($urandom % 32'hC000_0000);
        return 32'h1000_0400;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] ar, input logic [3:0] r,
                             input logic de);
        chk({tag, "_ar"}, {28'd0, bus.AR_arbiter}, {28'd0, ar});
        chk({tag, "_r"},  {28'd0, bus.R_arbiter},  {28'd0, r});
        chk({tag, "_de"}, {31'd0, bus.ar_decerr},  {31'd0, de});
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_arvalid(input int m, input logic v, input logic [31:0] a);
        if (m == 0) begin bus.ARVALID_M0 = v; bus.ARADDR_M0 = a; end
        else        begin bus.ARVALID_M1 = v; bus.ARADDR_M1 = a; end
    endtask

    task automatic set_arready(input int m, input logic v);
        if (m == 0) bus.ARREADY_M0 = v;
        else        bus.ARREADY_M1 = v;
    endtask

    task automatic set_r(input int m, input logic v, input logic rdy, input logic last);
        if (m == 0) begin bus.RVALID_M0 = v; bus.RREADY_M0 = rdy; bus.RLAST_M0 = last; end
        else        begin bus.RVALID_M1 = v; bus.RREADY_M1 = rdy; bus.RLAST_M1 = last; end
    endtask

    // Traffic on the non-granted master's muxed ready/R lines must be ignored
    task automatic noise_other(input int g);
        set_arready(1 - g, 1'($urandom % 2));
        set_r(1 - g, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
    endtask

    task automatic quiet_other(input int g);
        set_arready(1 - g, 1'b0);
        set_r(1 - g, 1'b0, 1'b0, 1'b0);
    endtask

    // Requests must already be driven; runs one full read and checks every cycle
    task automatic run_txn(input string tag, input int ar_wait, input int beats);
        int         g;
        logic [2:0] s;
        logic [3:0] e;
        if (bus.ARVALID_M0 && bus.ARVALID_M1) g = (rr_model == 1) ? 0 : 1;
        else                                  g = bus.ARVALID_M1 ? 1 : 0;
        s = ref_slv(g == 1 ? bus.ARADDR_M1 : bus.ARADDR_M0);
        e = {g[0], s};
        tick();
        check_out({tag, "_grant"}, e, c_IDLE_SEL, s == 3'd6);
        repeat (ar_wait) begin
            noise_other(g);
            tick();
            check_out({tag, "_hold"}, e, c_IDLE_SEL, 1'b0);
        end
        quiet_other(g);
        set_arready(g, 1'b1);
        tick();
        set_arready(g, 1'b0);
        set_arvalid(g, 1'b0, 32'h0);
        check_out({tag, "_arhs"}, c_IDLE_SEL, e, 1'b0);
        for (int b = 0; b < beats; b++) begin
            repeat ($urandom_range(0, 2)) begin
                int r = $urandom_range(0, 1);
                noise_other(g);
                set_r(g, r[0], ~r[0], b == beats - 1);
                tick();
                check_out({tag, "_rwait"}, c_IDLE_SEL, e, 1'b0);
            end
            quiet_other(g);
            set_r(g, 1'b1, 1'b1, b == beats - 1);
            tick();
            set_r(g, 1'b0, 1'b0, 1'b0);
            if (b == beats - 1) begin
                check_out({tag, "_done"}, c_IDLE_SEL, c_IDLE_SEL, 1'b0);
                rr_model = g;
            end else begin
                check_out({tag, "_beat"}, c_IDLE_SEL, e, 1'b0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        set_arvalid(0, 1'b0, 32'h0); set_arvalid(1, 1'b0, 32'h0);
        set_arready(0, 1'b0); set_arready(1, 1'b0);
        set_r(0, 1'b0, 1'b0, 1'b0); set_r(1, 1'b0, 1'b0, 1'b0);
        ARESETn = 1'b0;
        repeat (3) tick();
        check_out("reset", c_IDLE_SEL, c_IDLE_SEL, 1'b0);
        ARESETn  = 1'b1;
        rr_model = 1;

        // Simultaneous requests from reset: M0 first, M1 granted right after
        set_arvalid(0, 1'b1, 32'h0000_0000);
        set_arvalid(1, 1'b1, 32'h0000_0000);
        run_txn("t2_m0", 1, 2);
        run_txn("t2_m1", 0, 2);

        set_arvalid(0, 1'b1, 32'h0001_0040);
        run_txn("t1", 1, 4);

        set_arvalid(1, 1'b1, 32'h3000_0000);
        run_txn("t3", 0, 3);

        // M0 stalls on ARREADY while M1 waits
        set_arvalid(0, 1'b1, 32'h0002_0100);
        set_arvalid(1, 1'b1, 32'h1000_0000);
        run_txn("t4_m0", 5, 1);
        run_txn("t4_m1", 0, 2);

        // Back-to-back M0 reads across decode boundaries
        set_arvalid(0, 1'b1, 32'h0000_FFFF); run_txn("t6_a", 0, 1);
        set_arvalid(0, 1'b1, 32'h1000_03FF); run_txn("t6_b", 0, 2);
        set_arvalid(0, 1'b1, 32'h1000_0400); run_txn("t6_c", 0, 1);
        set_arvalid(0, 1'b1, 32'h201F_FFFF); run_txn("t6_d", 1, 1);
        set_arvalid(0, 1'b1, 32'h2020_0000); run_txn("t6_e", 0, 1);
        set_arvalid(0, 1'b1, 32'h1001_0000); run_txn("t6_f", 0, 1);

        // Reset during the second data beat of four
        set_arvalid(0, 1'b1, 32'h0002_0000);
        tick();
        check_out("t5_grant", 4'h2, c_IDLE_SEL, 1'b0);
        set_arready(0, 1'b1);
        tick();
        set_arready(0, 1'b0);
        set_arvalid(0, 1'b0, 32'h0);
        set_r(0, 1'b1, 1'b1, 1'b0);
        tick();
        check_out("t5_beat1", c_IDLE_SEL, 4'h2, 1'b0);
        ARESETn = 1'b0;
        tick();
        check_out("t5_reset", c_IDLE_SEL, c_IDLE_SEL, 1'b0);
        ARESETn = 1'b1;
        set_r(0, 1'b0, 1'b0, 1'b0);
        rr_model = 1;
        set_arvalid(0, 1'b1, 32'h0000_1234);
        set_arvalid(1, 1'b1, 32'h0001_1234);
        run_txn("t5_rr_m0", 0, 1);
        run_txn("t5_rr_m1", 0, 1);

        // Random traffic; a pending loser keeps its request and address
        for (int i = 0; i < 30; i++) begin
            if (!bus.ARVALID_M0 && ($urandom % 2 == 1)) set_arvalid(0, 1'b1, rand_addr());
            if (!bus.ARVALID_M1 && ($urandom % 2 == 1)) set_arvalid(1, 1'b1, rand_addr());
            if (!bus.ARVALID_M0 && !bus.ARVALID_M1) set_arvalid($urandom_range(0, 1), 1'b1, rand_addr());
            run_txn("rnd", $urandom_range(0, 3), $urandom_range(1, 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
